// File: rtl/clip_player_if.sv
// Control, sample-ROM and serializer-side signals of the clip player.
// master is the player itself; slave is the surrounding button/ROM/AC97 logic.
interface clip_player_if #(
   parameter int unsigned CW = 1,
   parameter int unsigned AW = 18,
   parameter int unsigned DW = 16
);
   logic [CW-1:0] clip_sel;
   logic          start;
   logic          stop;
   logic          smp_req;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] smp_data;
   logic          smp_valid;
   logic          busy;
   logic [CW-1:0] cur_clip;
   logic          done;

   modport master (
      input  clip_sel, start, stop, smp_req, mem_data,
      output mem_addr, smp_data, smp_valid, busy, cur_clip, done
   );

   modport slave (
      output clip_sel, start, stop, smp_req, mem_data,
      input  mem_addr, smp_data, smp_valid, busy, cur_clip, done
   );
endinterface

// File: rtl/clip_player.sv
// Clip player: answers each frame sample request with one ROM sample of the active clip, or silence.
// Optional macro CLIP_PLAYER_LOOP_EN: clips wrap to their first sample instead of returning to idle.
module clip_player #(
   parameter int unsigned          NCLIPS    = 2,
   parameter int unsigned          AW        = 18,
   parameter int unsigned          DW        = 16,
   parameter logic [NCLIPS*AW-1:0] CLIP_BASE = {18'd38097, 18'd0},
   parameter logic [NCLIPS*AW-1:0] CLIP_LEN  = {18'd45192, 18'd38097}
) (
   input logic           clk,
   input logic           rst_b,
   clip_player_if.master bus
);
   localparam int unsigned CW       = (NCLIPS > 2) ? $clog2(NCLIPS) : 1;
   localparam logic [CW:0] NCLIPS_W = (CW+1)'(NCLIPS);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PLAY = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cur_clip_q, cur_clip_d;
   logic [1:0]    pend_q, pend_d;
   logic          play_q, play_d;
   logic          last_q, last_d;
   logic          end_arm_q, end_arm_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] smp_data_q, smp_data_d;
   logic          smp_valid_q, smp_valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [0:0]    state_v;
   logic [AW-1:0] ptr_v;
   logic [CW-1:0] clip_v;
   logic          sel_ok;
   logic          accept;
   logic          is_last;

   function automatic logic [AW-1:0] clip_base(input logic [CW-1:0] idx);
      clip_base = '0;
      for (int i = 0; i < NCLIPS; i++)
         if (CW'(i) == idx) clip_base = CLIP_BASE[i*AW +: AW];
   endfunction

   function automatic logic [AW-1:0] clip_len(input logic [CW-1:0] idx);
      clip_len = AW'(1);
      for (int i = 0; i < NCLIPS; i++)
         if (CW'(i) == idx) clip_len = CLIP_LEN[i*AW +: AW];
   endfunction

   // Control events are applied first, so an accepted request sees the updated clip/pointer.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cur_clip_d  = cur_clip_q;
      pend_d      = {pend_q[0], 1'b0};
      play_d      = play_q;
      last_d      = last_q;
      end_arm_d   = end_arm_q;
      mem_addr_d  = mem_addr_q;
      smp_data_d  = smp_data_q;
      smp_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      state_v     = state_q;
      ptr_v       = ptr_q;
      clip_v      = cur_clip_q;
      is_last     = 1'b0;
      sel_ok      = ({1'b0, bus.clip_sel} < NCLIPS_W);
      accept      = bus.smp_req && (pend_q == 2'b00);

      if (bus.stop) begin
         state_v   = ST_IDLE;
         end_arm_d = 1'b0;
      end else if (bus.start && sel_ok) begin
         state_v   = ST_PLAY;
         clip_v    = bus.clip_sel;
         ptr_v     = '0;
         end_arm_d = 1'b0;
      end else if (done_q && end_arm_q) begin
         // Leave PLAY the cycle after the final sample was handed over.
         state_v   = ST_IDLE;
         end_arm_d = 1'b0;
      end

      if (accept) begin
         pend_d[0]  = 1'b1;
         mem_addr_d = clip_base(clip_v) + ptr_v;
         play_d     = (state_v == ST_PLAY);
         last_d     = 1'b0;
         if (state_v == ST_PLAY) begin
            is_last = (ptr_v == (clip_len(clip_v) - AW'(1)));
            last_d  = is_last;
`ifdef CLIP_PLAYER_LOOP_EN
            ptr_v = is_last ? '0 : ptr_v + AW'(1);
`else
            ptr_v = ptr_v + AW'(1);
            if (is_last) end_arm_d = 1'b1;
`endif
         end
      end

      if (pend_q[0]) begin
         smp_valid_d = 1'b1;
         smp_data_d  = play_q ? bus.mem_data : '0;
         done_d      = last_q;
      end

      state_d    = state_v;
      ptr_d      = ptr_v;
      cur_clip_d = clip_v;
      busy_d     = (state_v == ST_PLAY);
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         cur_clip_q  <= '0;
         pend_q      <= '0;
         play_q      <= 1'b0;
         last_q      <= 1'b0;
         end_arm_q   <= 1'b0;
         mem_addr_q  <= '0;
         smp_data_q  <= '0;
         smp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cur_clip_q  <= cur_clip_d;
         pend_q      <= pend_d;
         play_q      <= play_d;
         last_q      <= last_d;
         end_arm_q   <= end_arm_d;
         mem_addr_q  <= mem_addr_d;
         smp_data_q  <= smp_data_d;
         smp_valid_q <= smp_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.smp_data  = smp_data_q;
   assign bus.smp_valid = smp_valid_q;
   assign bus.busy      = busy_q;
   assign bus.cur_clip  = cur_clip_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_clip_player.sv
// Directed bench for clip_player: two clips {base 0 len 3, base 4 len 5}, ROM word k = 16'h1000+k.
// A second three-clip instance exercises out-of-range clip selects.
module tb_clip_player;
   localparam int unsigned AW = 18;
   localparam int unsigned DW = 16;

   logic clk;
   logic rst_b;
   int   total;
   int   bad;

   clip_player_if #(.CW(1), .AW(AW), .DW(DW)) bus ();
   clip_player_if #(.CW(2), .AW(AW), .DW(DW)) bus3 ();

   clip_player #(
      .NCLIPS(2), .AW(AW), .DW(DW),
      .CLIP_BASE({18'd4, 18'd0}),
      .CLIP_LEN({18'd5, 18'd3})
   ) dut (
      .clk(clk), .rst_b(rst_b), .bus(bus)
   );

   clip_player #(
      .NCLIPS(3), .AW(AW), .DW(DW),
      .CLIP_BASE({18'd8, 18'd4, 18'd0}),
      .CLIP_LEN({18'd2, 18'd5, 18'd3})
   ) dut3 (
      .clk(clk), .rst_b(rst_b), .bus(bus3)
   );

   // ROM output follows the registered address, ready for the next edge.
   assign bus.mem_data  = 16'h1000 + 16'(bus.mem_addr);
   assign bus3.mem_data = 16'h1000 + 16'(bus3.mem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [0:0] sel);
      bus.clip_sel = sel;
      bus.start    = 1'b1;
      step();
      bus.start    = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
   endtask

   // One request on an 8-cycle frame; returns what the DUT showed along the way.
   task automatic req(output logic [AW-1:0] addr, output logic v0, output logic v1,
                      output logic [DW-1:0] data, output logic dn,
                      output logic bz1, output logic bz2);
      bus.smp_req = 1'b1;
      step();
      addr = bus.mem_addr;
      v0   = bus.smp_valid;
      bus.smp_req = 1'b0;
      step();
      v1   = bus.smp_valid;
      data = bus.smp_data;
      dn   = bus.done;
      bz1  = bus.busy;
      step();
      bz2  = bus.busy;
      repeat (5) step();
   endtask

   task automatic req3(output logic [AW-1:0] addr, output logic v1,
                       output logic [DW-1:0] data, output logic dn);
      bus3.smp_req = 1'b1;
      step();
      addr = bus3.mem_addr;
      bus3.smp_req = 1'b0;
      step();
      v1   = bus3.smp_valid;
      data = bus3.smp_data;
      dn   = bus3.done;
      repeat (6) step();
   endtask

   task automatic test_reset();
      logic [AW-1:0] a;
      logic v0, v1, dn, b1, b2;
      logic [DW-1:0] d;
      rst_b = 1'b0;
      step();
      step();
      total++;
      if ({bus.mem_addr, bus.smp_data, bus.smp_valid, bus.busy, bus.cur_clip, bus.done} !== '0) begin
         bad++;
         $display("FAIL reset_outs got addr=%0h data=%0h v=%b busy=%b clip=%0d done=%b want all 0",
                  bus.mem_addr, bus.smp_data, bus.smp_valid, bus.busy, bus.cur_clip, bus.done);
      end
      rst_b = 1'b1;
      step();
      for (int i = 0; i < 2; i++) begin
         req(a, v0, v1, d, dn, b1, b2);
         total++;
         if ({v0, v1} !== 2'b01) begin
            bad++;
            $display("FAIL idle_latency[%0d] got v@1=%b v@2=%b want 0 1", i, v0, v1);
         end
         total++;
         if (d !== 16'h0000 || dn !== 1'b0) begin
            bad++;
            $display("FAIL idle_silence[%0d] got data=%h done=%b want 0000 0", i, d, dn);
         end
         total++;
         if (a !== '0 || b1 !== 1'b0) begin
            bad++;
            $display("FAIL idle_addr_busy[%0d] got addr=%0h busy=%b want 0 0", i, a, b1);
         end
      end
   endtask

   task automatic test_clip0();
      logic [AW-1:0] a;
      logic v0, v1, dn, b1, b2;
      logic [DW-1:0] d;
      pulse_start(1'b0);
      total++;
      if (bus.busy !== 1'b1 || bus.cur_clip !== 1'b0) begin
         bad++;
         $display("FAIL clip0_start got busy=%b clip=%0d want 1 0", bus.busy, bus.cur_clip);
      end
      for (int i = 0; i < 3; i++) begin
         req(a, v0, v1, d, dn, b1, b2);
         total++;
         if (a !== AW'(i) || v1 !== 1'b1 || d !== 16'(16'h1000 + i) || dn !== (i == 2)) begin
            bad++;
            $display("FAIL clip0_smp[%0d] got addr=%0h v=%b data=%h done=%b want %0h 1 %h %b",
                     i, a, v1, d, dn, i, 16'h1000 + i, (i == 2));
         end
      end
`ifdef CLIP_PLAYER_LOOP_EN
      total++;
      if (b1 !== 1'b1 || b2 !== 1'b1) begin
         bad++;
         $display("FAIL clip0_wrap_busy got %b %b want 1 1", b1, b2);
      end
      for (int i = 0; i < 3; i++) begin
         req(a, v0, v1, d, dn, b1, b2);
         total++;
         if (a !== AW'(i) || d !== 16'(16'h1000 + i) || dn !== (i == 2)) begin
            bad++;
            $display("FAIL clip0_loop[%0d] got addr=%0h data=%h done=%b want %0h %h %b",
                     i, a, d, dn, i, 16'h1000 + i, (i == 2));
         end
      end
      pulse_stop();
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL clip0_stop_busy got %b want 0", bus.busy);
      end
`else
      total++;
      if (b1 !== 1'b1 || b2 !== 1'b0) begin
         bad++;
         $display("FAIL clip0_end_busy got at_done=%b next=%b want 1 0", b1, b2);
      end
      req(a, v0, v1, d, dn, b1, b2);
      total++;
      if (v1 !== 1'b1 || d !== 16'h0000 || dn !== 1'b0 || a !== AW'(3)) begin
         bad++;
         $display("FAIL clip0_after_end got v=%b data=%h done=%b addr=%0h want 1 0000 0 3",
                  v1, d, dn, a);
      end
`endif
   endtask

   task automatic test_clip1();
      logic [AW-1:0] a;
      logic v0, v1, dn, b1, b2;
      logic [DW-1:0] d;
      pulse_start(1'b1);
      total++;
      if (bus.busy !== 1'b1 || bus.cur_clip !== 1'b1) begin
         bad++;
         $display("FAIL clip1_start got busy=%b clip=%0d want 1 1", bus.busy, bus.cur_clip);
      end
      for (int i = 0; i < 5; i++) begin
         req(a, v0, v1, d, dn, b1, b2);
         total++;
         if (a !== AW'(4 + i) || v1 !== 1'b1 || d !== 16'(16'h1004 + i) || dn !== (i == 4)) begin
            bad++;
            $display("FAIL clip1_smp[%0d] got addr=%0h v=%b data=%h done=%b want %0h 1 %h %b",
                     i, a, v1, d, dn, 4 + i, 16'h1004 + i, (i == 4));
         end
      end
`ifdef CLIP_PLAYER_LOOP_EN
      pulse_stop();
      b2 = bus.busy;
`endif
      total++;
      if (b2 !== 1'b0 || bus.cur_clip !== 1'b1) begin
         bad++;
         $display("FAIL clip1_idle got busy=%b clip=%0d want 0 1", b2, bus.cur_clip);
      end
   endtask

   task automatic test_stop();
      logic [AW-1:0] a;
      logic v0, v1, dn, b1, b2;
      logic [DW-1:0] d;
      pulse_start(1'b1);
      req(a, v0, v1, d, dn, b1, b2);
      total++;
      if (d !== 16'h1004) begin
         bad++;
         $display("FAIL stop_first got %h want 1004", d);
      end
      bus.smp_req = 1'b1;
      step();
      bus.smp_req = 1'b0;
      bus.stop    = 1'b1;
      step();
      bus.stop    = 1'b0;
      total++;
      if (bus.smp_valid !== 1'b1 || bus.smp_data !== 16'h1005 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL stop_inflight got v=%b data=%h busy=%b want 1 1005 0",
                  bus.smp_valid, bus.smp_data, bus.busy);
      end
      repeat (6) step();
      req(a, v0, v1, d, dn, b1, b2);
      total++;
      if (v1 !== 1'b1 || d !== 16'h0000) begin
         bad++;
         $display("FAIL stop_silence got v=%b data=%h want 1 0000", v1, d);
      end
      bus.clip_sel = 1'b0;
      bus.start    = 1'b1;
      bus.stop     = 1'b1;
      step();
      bus.start    = 1'b0;
      bus.stop     = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || bus.cur_clip !== 1'b1) begin
         bad++;
         $display("FAIL start_stop_same got busy=%b clip=%0d want 0 1", bus.busy, bus.cur_clip);
      end
      req(a, v0, v1, d, dn, b1, b2);
      total++;
      if (d !== 16'h0000 || b1 !== 1'b0) begin
         bad++;
         $display("FAIL start_stop_silence got data=%h busy=%b want 0000 0", d, b1);
      end
   endtask

   task automatic test_restart();
      logic [AW-1:0] a;
      logic v0, v1, dn, b1, b2;
      logic [DW-1:0] d;
      pulse_start(1'b1);
      req(a, v0, v1, d, dn, b1, b2);
      req(a, v0, v1, d, dn, b1, b2);
      total++;
      if (d !== 16'h1005) begin
         bad++;
         $display("FAIL restart_pre got %h want 1005", d);
      end
      bus.clip_sel = 1'b0;
      bus.start    = 1'b1;
      bus.smp_req  = 1'b1;
      step();
      bus.start    = 1'b0;
      bus.smp_req  = 1'b0;
      total++;
      if (bus.mem_addr !== AW'(0) || bus.cur_clip !== 1'b0 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL restart_addr got addr=%0h clip=%0d busy=%b want 0 0 1",
                  bus.mem_addr, bus.cur_clip, bus.busy);
      end
      step();
      total++;
      if (bus.smp_valid !== 1'b1 || bus.smp_data !== 16'h1000) begin
         bad++;
         $display("FAIL restart_data got v=%b data=%h want 1 1000", bus.smp_valid, bus.smp_data);
      end
      repeat (6) step();
      req(a, v0, v1, d, dn, b1, b2);
      total++;
      if (d !== 16'h1001 || a !== AW'(1)) begin
         bad++;
         $display("FAIL restart_next got data=%h addr=%0h want 1001 1", d, a);
      end
      pulse_stop();
   endtask

   task automatic test_sel_range();
      logic [AW-1:0] a;
      logic v1, dn;
      logic [DW-1:0] d;
      bus3.clip_sel = 2'd3;
      bus3.start    = 1'b1;
      step();
      bus3.start    = 1'b0;
      total++;
      if (bus3.busy !== 1'b0 || bus3.cur_clip !== 2'd0) begin
         bad++;
         $display("FAIL sel_bad_idle got busy=%b clip=%0d want 0 0", bus3.busy, bus3.cur_clip);
      end
      req3(a, v1, d, dn);
      total++;
      if (v1 !== 1'b1 || d !== 16'h0000) begin
         bad++;
         $display("FAIL sel_bad_silence got v=%b data=%h want 1 0000", v1, d);
      end
      bus3.clip_sel = 2'd2;
      bus3.start    = 1'b1;
      step();
      bus3.start    = 1'b0;
      req3(a, v1, d, dn);
      total++;
      if (a !== AW'(8) || d !== 16'h1008 || dn !== 1'b0 || bus3.cur_clip !== 2'd2) begin
         bad++;
         $display("FAIL sel2_first got addr=%0h data=%h done=%b clip=%0d want 8 1008 0 2",
                  a, d, dn, bus3.cur_clip);
      end
      bus3.clip_sel = 2'd3;
      bus3.start    = 1'b1;
      step();
      bus3.start    = 1'b0;
      total++;
      if (bus3.busy !== 1'b1 || bus3.cur_clip !== 2'd2) begin
         bad++;
         $display("FAIL sel_bad_play got busy=%b clip=%0d want 1 2", bus3.busy, bus3.cur_clip);
      end
      req3(a, v1, d, dn);
      total++;
      if (a !== AW'(9) || d !== 16'h1009 || dn !== 1'b1) begin
         bad++;
         $display("FAIL sel2_last got addr=%0h data=%h done=%b want 9 1009 1", a, d, dn);
      end
      bus3.stop = 1'b1;
      step();
      bus3.stop = 1'b0;
   endtask

   task automatic test_back_to_back();
      int            nv;
      logic [DW-1:0] got [2];
      nv     = 0;
      got[0] = '0;
      got[1] = '0;
      pulse_start(1'b1);
      bus.smp_req = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c == 4) bus.smp_req = 1'b0;
         step();
         if (bus.smp_valid === 1'b1) begin
            if (nv < 2) got[nv] = bus.smp_data;
            nv++;
         end
      end
      total++;
      if (nv != 2 || got[0] !== 16'h1004 || got[1] !== 16'h1005) begin
         bad++;
         $display("FAIL b2b_drop got count=%0d data=%h,%h want 2 1004,1005", nv, got[0], got[1]);
      end
      pulse_stop();
      pulse_start(1'b1);
      bus.smp_req = 1'b1;
      step();
      bus.smp_req = 1'b0;
      rst_b       = 1'b0;
      step();
      total++;
      if ({bus.mem_addr, bus.smp_data, bus.smp_valid, bus.busy, bus.cur_clip, bus.done} !== '0) begin
         bad++;
         $display("FAIL reset_inflight got addr=%0h data=%h v=%b busy=%b clip=%0d done=%b want all 0",
                  bus.mem_addr, bus.smp_data, bus.smp_valid, bus.busy, bus.cur_clip, bus.done);
      end
      rst_b = 1'b1;
      nv    = 0;
      repeat (4) begin
         step();
         if (bus.smp_valid !== 1'b0) nv++;
      end
      total++;
      if (nv != 0) begin
         bad++;
         $display("FAIL reset_discard got %0d stray smp_valid want 0", nv);
      end
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      rst_b         = 1'b0;
      bus.clip_sel  = '0;
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      bus.smp_req   = 1'b0;
      bus3.clip_sel = '0;
      bus3.start    = 1'b0;
      bus3.stop     = 1'b0;
      bus3.smp_req  = 1'b0;
      test_reset();
      test_clip0();
      test_clip1();
      test_stop();
      test_restart();
      test_sel_range();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
